// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: two-flop synchroniser, per-bit debounce, sticky edge
// capture with maskable interrupt, and a small register slot on the peripheral bus.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module gpio_in_filter #(
    parameter  int W          = 8,
    parameter  int DEB_CYCLES = 16,
    localparam int CW         = $clog2(DEB_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [W-1:0]              pad_i,
    output logic [W-1:0]              i_o,
    output logic                      irq,
    input  logic [3:0]                addr,
    input  logic                      w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     rdata,
    input  logic [`BUS_WIDTH-1:0]     wdata,
    input  logic                      req,
    output logic                      resp,
    output logic                      fault
);

    typedef enum logic [3:0] {
        REG_LVL  = 4'h0,
        REG_RISE = 4'h4,
        REG_FALL = 4'h8,
        REG_IE   = 4'hC
    } reg_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  s1, s2;
    logic [CW-1:0] cnt [W];
    logic [W-1:0]  rise, fall, ie;
    logic [W-1:0]  take, rise_set, fall_set;
    logic [W-1:0]  rise_clr, fall_clr;
    logic          addr_ok, valid, accept, ie_wr;
    logic [`BUS_WIDTH-1:0] rd_val;
    logic          unused_bits;

    // Upper write-data bits beyond W have no storage behind them.
    assign unused_bits = &{1'b0, wdata};

    // A bit changes level once its counter has seen DEB_CYCLES mismatching cycles.
    always_comb begin
        for (int b = 0; b < W; b++) begin
            take[b] = (s2[b] != i_o[b]) && (cnt[b] == CNT_MAX);
        end
        rise_set = take & s2;
        fall_set = take & ~s2;
    end

    // NOTE: every variable driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        addr_ok  = 1'b0;
        rd_val   = '0;
        rise_clr = '0;
        fall_clr = '0;
        ie_wr    = 1'b0;
        case (addr)
            REG_LVL:  begin addr_ok = 1'b1; rd_val[W-1:0] = i_o;  end
            REG_RISE: begin addr_ok = 1'b1; rd_val[W-1:0] = rise; end
            REG_FALL: begin addr_ok = 1'b1; rd_val[W-1:0] = fall; end
            REG_IE:   begin addr_ok = 1'b1; rd_val[W-1:0] = ie;   end
            default:  addr_ok = 1'b0;
        endcase
        valid  = addr_ok && (acc == `BUS_ACC_4B) && !(w_rb && (addr == REG_LVL));
        accept = req && valid;
        if (accept && w_rb) begin
            case (addr)
                REG_RISE: rise_clr = wdata[W-1:0];
                REG_FALL: fall_clr = wdata[W-1:0];
                REG_IE:   ie_wr    = 1'b1;
                default:  ie_wr    = 1'b0;
            endcase
        end
    end

    assign fault = req && !valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, which the synchroniser chain relies on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1  <= '0;
            s2  <= '0;
            i_o <= '0;
            // NOTE: the counter array is small flop storage, not a RAM, so it is
            // cleared with the rest of the state to make mid-debounce reset clean.
            for (int b = 0; b < W; b++) cnt[b] <= '0;
        end else begin
            s1 <= pad_i;
            s2 <= s1;
            for (int b = 0; b < W; b++) begin
                if (s2[b] == i_o[b]) begin
                    cnt[b] <= '0;
                end else if (take[b]) begin
                    i_o[b] <= s2[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    // Hardware set wins over a same-cycle software clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise <= '0;
            fall <= '0;
            ie   <= '0;
            irq  <= 1'b0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (ie_wr) ie <= wdata[W-1:0];
            irq  <= |((rise | fall) & ie);
        end
    end

    // rdata holds the last valid read; writes and faults leave it untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            resp <= accept;
            if (accept && !w_rb) rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter with DEB_CYCLES=4: latency, glitch rejection,
// interrupt, W1C collision, bus faults and asynchronous reset.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module tb_gpio_in_filter;

    localparam int W = 8;
    localparam logic [`BUS_ACC_WIDTH-1:0] ACC4 = `BUS_ACC_4B;
    localparam logic [`BUS_ACC_WIDTH-1:0] ACC1 = '0;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic [W-1:0]              pad;
    logic [W-1:0]              lvl;
    logic                      irq;
    logic [3:0]                addr;
    logic                      w_rb;
    logic [`BUS_ACC_WIDTH-1:0] acc;
    logic [`BUS_WIDTH-1:0]     rdata;
    logic [`BUS_WIDTH-1:0]     wdata;
    logic                      req;
    logic                      resp;
    logic                      fault;

    int checks = 0;
    int errors = 0;

    gpio_in_filter #(.W(W), .DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .pad_i (pad),
        .i_o   (lvl),
        .irq   (irq),
        .addr  (addr),
        .w_rb  (w_rb),
        .acc   (acc),
        .rdata (rdata),
        .wdata (wdata),
        .req   (req),
        .resp  (resp),
        .fault (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transaction spanning exactly one clock edge.
    task automatic bus(input logic wr, input logic [3:0] a, input logic [`BUS_ACC_WIDTH-1:0] ac,
                       input logic [31:0] wd, input logic exp_fault, input string tag);
        req = 1'b1; w_rb = wr; addr = a; acc = ac; wdata = wd;
        #1;
        check({tag, " fault"}, 32'(fault), 32'(exp_fault));
        tick();
        req = 1'b0; w_rb = 1'b0; wdata = '0;
        check({tag, " resp"}, 32'(resp), 32'(!exp_fault));
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus(1'b0, a, ACC4, 32'h0, 1'b0, tag);
        check({tag, " rdata"}, rdata, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
        bus(1'b1, a, ACC4, d, 1'b0, tag);
    endtask

    initial begin
        rstn = 1'b0; pad = '0; addr = '0; w_rb = 1'b0; acc = ACC4; wdata = '0; req = 1'b0;
        #22;
        check("reset lvl", 32'(lvl), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset resp", 32'(resp), 32'h0);
        check("reset rdata", rdata, 32'h0);
        rstn = 1'b1;
        tick(3);

        // Latency: step sampled at edge 1, level changes at edge 6.
        pad = 8'h01;
        tick(5);
        check("latency edge5", 32'(lvl), 32'h00);
        tick();
        check("latency edge6", 32'(lvl), 32'h01);
        rd(4'h4, 32'h01, "rise after step");
        check("irq masked", 32'(irq), 32'h0);
        rd(4'h0, 32'h01, "lvl read");

        // Glitch of 3 cycles is rejected; 6 cycles is accepted.
        wr(4'h4, 32'hFF, "clear rise");
        pad = 8'h03;
        tick(3);
        pad = 8'h01;
        tick(8);
        check("glitch lvl", 32'(lvl), 32'h01);
        rd(4'h4, 32'h00, "glitch rise");
        rd(4'h8, 32'h00, "glitch fall");
        pad = 8'h03;
        tick(5);
        check("long pulse edge5", 32'(lvl), 32'h01);
        tick();
        check("long pulse edge6", 32'(lvl), 32'h03);
        rd(4'h4, 32'h02, "long pulse rise");

        // Interrupt on a falling edge of bit 0.
        wr(4'h4, 32'hFF, "clear rise 2");
        wr(4'hC, 32'h03, "ie write");
        tick();
        check("irq idle", 32'(irq), 32'h0);
        pad = 8'h02;
        tick(6);
        check("fall lvl", 32'(lvl), 32'h02);
        check("irq lags fall", 32'(irq), 32'h0);
        tick();
        check("irq set", 32'(irq), 32'h1);
        rd(4'h8, 32'h01, "fall set");
        wr(4'h8, 32'h01, "fall clear");
        check("irq lags clear", 32'(irq), 32'h1);
        tick();
        check("irq cleared", 32'(irq), 32'h0);
        rd(4'h8, 32'h00, "fall after clear");

        // W1C collision: clear RISE[1] in the cycle it is set.
        pad = 8'h00;
        tick(8);
        wr(4'h8, 32'hFF, "clear fall 2");
        pad = 8'h02;
        tick(5);
        wr(4'h4, 32'h02, "collision write");
        check("collision lvl", 32'(lvl), 32'h02);
        rd(4'h4, 32'h02, "collision rise kept");
        wr(4'h4, 32'h02, "plain w1c");
        rd(4'h4, 32'h00, "plain w1c result");

        // Faults.
        rd(4'hC, 32'h03, "ie read");
        bus(1'b0, 4'h2, ACC4, 32'h0, 1'b1, "bad addr");
        check("bad addr rdata held", rdata, 32'h03);
        bus(1'b1, 4'h0, ACC4, 32'hFF, 1'b1, "write lvl");
        rd(4'h0, 32'h02, "lvl unchanged");
        bus(1'b0, 4'hC, ACC1, 32'h0, 1'b1, "byte read ie");
        bus(1'b1, 4'hC, ACC1, 32'h0, 1'b1, "byte write ie");
        rd(4'hC, 32'h03, "ie unchanged");

        // Back-to-back requests.
        req = 1'b1; w_rb = 1'b0; acc = ACC4; addr = 4'hC;
        tick();
        check("b2b first resp", 32'(resp), 32'h1);
        check("b2b first rdata", rdata, 32'h03);
        addr = 4'h0;
        tick();
        check("b2b second resp", 32'(resp), 32'h1);
        check("b2b second rdata", rdata, 32'h02);
        req = 1'b0;
        tick();
        check("b2b idle resp", 32'(resp), 32'h0);

        // Asynchronous reset in the middle of a debounce.
        pad = 8'h03;
        tick(6);
        check("pre-reset lvl", 32'(lvl), 32'h03);
        tick();
        check("pre-reset irq", 32'(irq), 32'h1);
        pad = 8'h02;
        tick(4);
        #2;
        rstn = 1'b0;
        #1;
        check("async lvl", 32'(lvl), 32'h0);
        check("async irq", 32'(irq), 32'h0);
        check("async resp", 32'(resp), 32'h0);
        check("async rdata", rdata, 32'h0);
        #3;
        rstn = 1'b1;
        tick();
        rd(4'h4, 32'h00, "rise after reset");
        rd(4'h8, 32'h00, "fall after reset");
        rd(4'hC, 32'h00, "ie after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
